// File: rtl/vga_pkg.sv
// Shared timing defaults, colour type, colour-bar table and sync polarity helper for the VGA generator.
// Pure declarations; no latency or flow control of its own.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t COLOUR_BARS [8] = '{
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'h00, 8'h00, 8'h00}
  };

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with raw sync and active flags decoded from the count.
// Count advances the cycle after enable; flags are combinational from the count; no backpressure.
module vga_axis_counter #(
  parameter int TOTAL  = 800,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_raw,
  output logic         active_raw
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  assign wrap       = (count == LAST);
  assign sync_raw   = (count >= SYNC_START) && (count < SYNC_END);
  assign active_raw = (count < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-enable divider, h/v counters, aligned syncs/blank and re-timed colour; VGA_TEST_PATTERN_EN adds colour bars.
// Syncs, n_blank and colour lag pixel_x/pixel_y by PIPE_LAT+1 pixel ticks; free-running, no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAT = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [23:0]   rgb_in,
  input  logic          pattern_sel,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          pixel_tick,
  output logic          frame_start,
  output logic          line_start,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          vgaclock,
  output logic          hsync,
  output logic          vsync,
  output logic          n_blank
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE_LAT < 0) begin : g_bad_lat
    $error("vga_timing_gen: PIPE_LAT must be >= 0");
  end

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt, div_next;
  logic          h_wrap, unused_v_wrap;
  logic          hs_raw, vs_raw, h_act, v_act, act_raw;

  assign pixel_tick = (div_cnt == DIV_LAST);
  assign div_next   = pixel_tick ? '0 : div_cnt + DW'(1);

  // vgaclock tracks div_cnt >= CLK_DIV/2 exactly, so its rising edge sits mid-pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      vgaclock <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      vgaclock <= (div_next >= DIV_HALF);
    end
  end

  vga_axis_counter #(.TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC)) u_h_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (pixel_tick),
    .count      (pixel_x),
    .wrap       (h_wrap),
    .sync_raw   (hs_raw),
    .active_raw (h_act)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC)) u_v_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (pixel_tick && h_wrap),
    .count      (pixel_y),
    .wrap       (unused_v_wrap),
    .sync_raw   (vs_raw),
    .active_raw (v_act)
  );

  assign act_raw     = h_act && v_act;
  assign line_start  = pixel_tick && (pixel_x == '0);
  assign frame_start = line_start && (pixel_y == '0);

  // Chain element i is the raw flag delayed by i ticks; element 0 is the live decode.
  logic [PIPE_LAT:0]   hs_sr, vs_sr, act_sr;
  logic [PIPE_LAT+1:0] hs_chain, vs_chain, act_chain;
  rgb_t                src_colour, colour_q;

  assign hs_chain  = {hs_sr, hs_raw};
  assign vs_chain  = {vs_sr, vs_raw};
  assign act_chain = {act_sr, act_raw};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_sr    <= '0;
      vs_sr    <= '0;
      act_sr   <= '0;
      colour_q <= '0;
    end else if (pixel_tick) begin
      hs_sr    <= hs_chain[PIPE_LAT:0];
      vs_sr    <= vs_chain[PIPE_LAT:0];
      act_sr   <= act_chain[PIPE_LAT:0];
      colour_q <= act_chain[PIPE_LAT] ? src_colour : '0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]               bar_raw;
  logic [PIPE_LAT:0][2:0]   bar_sr;
  logic [PIPE_LAT+1:0][2:0] bar_chain;
  logic [2:0]               unused_bar_top;

  // Out-of-range values beyond H_ACTIVE are masked by blanking downstream.
  assign bar_raw        = 3'((32'(pixel_x) * 32'd8) / 32'(H_ACTIVE));
  assign bar_chain      = {bar_sr, bar_raw};
  assign unused_bar_top = bar_chain[PIPE_LAT+1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bar_sr <= '0;
    end else if (pixel_tick) begin
      bar_sr <= bar_chain[PIPE_LAT:0];
    end
  end

  assign src_colour = pattern_sel ? COLOUR_BARS[bar_chain[PIPE_LAT]] : rgb_in;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign src_colour         = rgb_in;
`endif

  assign red     = colour_q.r;
  assign green   = colour_q.g;
  assign blue    = colour_q.b;
  assign hsync   = sync_level(hs_chain[PIPE_LAT+1], SYNC_POL);
  assign vsync   = sync_level(vs_chain[PIPE_LAT+1], SYNC_POL);
  assign n_blank = act_chain[PIPE_LAT+1];

endmodule
